// File: rtl/ternary_decompress_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ternary_decompress_if                                           |
// | Brief    : Word-in / trit-beat-out stream bundle for ternary_decompress.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface ternary_decompress_if #(
  parameter int NUM_BYTES = 4
);
  localparam int IDX_W = $clog2(NUM_BYTES);

  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [8*NUM_BYTES-1:0] in_data_i;
  logic [IDX_W-1:0]       in_nbytes_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [9:0]             out_trits_o;
  logic                   out_last_o;
  logic                   out_invalid_o;

  // Stream source / sink side (drives words, consumes beats).
  modport master (
    output in_valid_i, in_data_i, in_nbytes_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_trits_o, out_last_o, out_invalid_o
  );

  // Decompressor side.
  modport slave (
    input  in_valid_i, in_data_i, in_nbytes_i, out_ready_i,
    output in_ready_o, out_valid_o, out_trits_o, out_last_o, out_invalid_o
  );
endinterface
`default_nettype wire

// File: rtl/ternary_decompress.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ternary_decompress                                              |
// | Brief    : Unpacks base-3 coded bytes (5 trits each) into 2-bit trit beats.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ternary_decompress #(
  parameter int NUM_BYTES = 4,
  localparam int IDX_W    = $clog2(NUM_BYTES)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clear_i,
  input  wire logic              err_clr_i,
  output logic                   err_o,
  ternary_decompress_if.slave    bus
);

  localparam logic [7:0] c_MAX_CODE = 8'd242;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                 r_state;
  logic [8*NUM_BYTES-1:0] r_word;
  logic [IDX_W-1:0]       r_nb;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_out_valid;
  logic [9:0]             r_trits;
  logic                   r_last;
  logic                   r_invalid;
  logic                   r_err;

  logic                   w_busy;
  logic                   w_load;
  logic [IDX_W+2:0]       w_offset;
  logic [7:0]             w_byte;
  logic                   w_last_byte;
  logic                   w_illegal;
  logic [9:0]             w_trits_raw;
  logic [9:0]             w_trits;

  assign w_busy      = (r_state == ST_DRAIN);
  assign w_load      = w_busy && (!r_out_valid || bus.out_ready_i);
  assign w_offset    = {r_idx, 3'b000};
  assign w_byte      = r_word[w_offset +: 8];
  assign w_last_byte = (r_idx == r_nb);
  assign w_illegal   = (w_byte > c_MAX_CODE);

  // Base-3 digit i of the code is (t_i + 1); map digit 0/1/2 to -1/0/+1.
  for (genvar gi = 0; gi < 5; gi++) begin : g_trit
    localparam int unsigned c_POW = 3 ** gi;
    logic [1:0] w_digit;
    assign w_digit = 2'((32'(w_byte) / c_POW) % 32'd3);
    assign w_trits_raw[2*gi +: 2] = (w_digit == 2'd0) ? 2'b11 :
                                    (w_digit == 2'd1) ? 2'b00 : 2'b01;
  end

  assign w_trits = w_illegal ? 10'd0 : w_trits_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_nb        <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_trits     <= '0;
      r_last      <= 1'b0;
      r_invalid   <= 1'b0;
      r_err       <= 1'b0;
    end else if (clear_i) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_nb        <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_trits     <= '0;
      r_last      <= 1'b0;
      r_invalid   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Set beats clear when both happen in the same cycle.
      if (w_load && w_illegal) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_trits     <= w_trits;
        r_invalid   <= w_illegal;
        r_last      <= w_last_byte;
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            r_word  <= bus.in_data_i;
            r_nb    <= bus.in_nbytes_i;
            r_idx   <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_load) begin
            if (w_last_byte) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o    = !w_busy;
  assign bus.out_valid_o   = r_out_valid;
  assign bus.out_trits_o   = r_trits;
  assign bus.out_last_o    = r_last;
  assign bus.out_invalid_o = r_invalid;
  assign err_o             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ternary_decompress.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ternary_decompress                                           |
// | Brief    : Randomised + directed self-checking bench for ternary_decompress|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ternary_decompress;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_i;
  logic err_clr_i;
  logic err_o;

  ternary_decompress_if #(.NUM_BYTES(NB)) bus ();

  ternary_decompress #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .err_clr_i (err_clr_i),
    .err_o     (err_o),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference decode: {invalid, trits}, trit i = floor(v/3^i) mod 3 - 1 in 2-bit two's complement.
  function automatic logic [10:0] ref_decode(input int v);
    logic [9:0] t;
    int pw;
    logic signed [1:0] s;
    t = '0;
    if (v > 242) return {1'b1, 10'd0};
    pw = 1;
    for (int i = 0; i < 5; i++) begin
      s = 2'((v / pw) % 3 - 1);
      t[2*i +: 2] = s;
      pw = pw * 3;
    end
    return {1'b0, t};
  endfunction

  logic [11:0] exp_q[$];   // {last, invalid, trits}
  logic        model_err;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic        stall_pending = 1'b0;
  logic [11:0] held;
  int          rdy_mode = 0;
  int          pat_idx = 0;
  int          pat[6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus.out_ready_i = 1'($urandom_range(0, 1));
      2: begin bus.out_ready_i = 1'(pat[pat_idx]); pat_idx = (pat_idx + 1) % 6; end
      default: bus.out_ready_i = 1'b1;
    endcase
  end

  // Scoreboard: inputs are stable at the falling edge, so a handshake seen here completes next rising edge.
  always @(negedge clk) begin
    logic [11:0] e;
    logic [10:0] d;
    if (!rst_n || clear_i) begin
      exp_q.delete();
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid", 32'(bus.out_valid_o), 32'd1);
        check("stall_hold", 32'({bus.out_last_o, bus.out_invalid_o, bus.out_trits_o}), 32'(held));
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'({bus.out_last_o, bus.out_invalid_o, bus.out_trits_o}), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("beat_trits", 32'(bus.out_trits_o), 32'(e[9:0]));
          check("beat_inv", 32'(bus.out_invalid_o), 32'(e[10]));
          check("beat_last", 32'(bus.out_last_o), 32'(e[11]));
        end
      end
      stall_pending = bus.out_valid_o && !bus.out_ready_i;
      held = {bus.out_last_o, bus.out_invalid_o, bus.out_trits_o};
      if (bus.in_valid_i && bus.in_ready_o) begin
        accept_cyc = cyc;
        for (int b = 0; b <= int'(bus.in_nbytes_i); b++) begin
          d = ref_decode(int'(bus.in_data_i[8*b +: 8]));
          if (d[10]) model_err = 1'b1;
          exp_q.push_back({(b == int'(bus.in_nbytes_i)), d});
        end
      end
    end
  end

  task automatic send_word(input logic [8*NB-1:0] data, input int nb);
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = data;
    bus.in_nbytes_i = 2'(nb);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.in_ready_o) break;
      if (t > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.in_ready_o && !bus.out_valid_o) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int a0;
    int codes[4] = '{8'h00, 8'h79, 8'hF2, 8'h05};
    int exps[4]  = '{10'h3FF, 10'h000, 10'h155, 10'h3F1};
    logic [7:0] b;
    logic [8*NB-1:0] w;

    rst_n = 1'b0; clear_i = 1'b0; err_clr_i = 1'b0; model_err = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_nbytes_i = '0; bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_trits", 32'(bus.out_trits_o), 32'd0);
    check("rst_last", 32'(bus.out_last_o), 32'd0);
    check("rst_invalid", 32'(bus.out_invalid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // Single bytes: explicit expected trits plus one-cycle latency.
    for (int i = 0; i < 4; i++) begin
      send_word(32'(codes[i]), 0);
      check("lat_pre_valid", 32'(bus.out_valid_o), 32'd0);
      tick();
      check("lat_valid", 32'(bus.out_valid_o), 32'd1);
      check("single_trits", 32'(bus.out_trits_o), 32'(exps[i]));
      check("single_last", 32'(bus.out_last_o), 32'd1);
      drain();
    end

    // Full word, ready high: busy for 4 cycles, next accept 5 cycles later.
    send_word(32'hF279_0005, 3);
    a0 = accept_cyc;
    for (int i = 0; i < 4; i++) begin
      check("busy_ready", 32'(bus.in_ready_o), 32'd0);
      tick();
    end
    check("ready_back", 32'(bus.in_ready_o), 32'd1);
    send_word(32'hF279_0005, 3);
    check("accept_spacing", 32'(accept_cyc - a0), 32'd5);
    drain();

    // Same word under a toggling ready pattern.
    pat_idx = 0; rdy_mode = 2;
    send_word(32'hF279_0005, 3);
    drain();
    rdy_mode = 0; tick();

    // Illegal code, sticky error, set-over-clear, then clear alone.
    send_word(32'h0000_00F3, 0);
    drain();
    check("err_set", 32'(err_o), 32'd1);
    repeat (3) tick();
    check("err_sticky", 32'(err_o), 32'd1);
    send_word(32'h0000_00FF, 0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("err_set_wins", 32'(err_o), 32'd1);
    drain();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    check("err_cleared", 32'(err_o), 32'd0);

    // Bytes above nb are ignored.
    send_word(32'hFFFF_7900, 1);
    drain();
    check("nb_ignore_err", 32'(err_o), 32'd0);

    // clear_i during beat 1, then rst_n during beat 1.
    for (int k = 0; k < 2; k++) begin
      send_word(32'h1234_5678, 3);
      tick();
      tick();
      check("flush_pre_valid", 32'(bus.out_valid_o), 32'd1);
      if (k == 0) begin
        clear_i = 1'b1; tick(); clear_i = 1'b0;
      end else begin
        rst_n = 1'b0; #1;
        check("async_rst_valid", 32'(bus.out_valid_o), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
      end
      check("flush_valid", 32'(bus.out_valid_o), 32'd0);
      check("flush_ready", 32'(bus.in_ready_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("flush_no_beat", 32'(bus.out_valid_o), 32'd0);
      end
      tick();
      send_word(32'h00F2_7905, 3);
      drain();
    end

    // Randomised traffic with random backpressure.
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    model_err = 1'b0;
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < NB; j++) begin
        b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(243, 255)) : 8'($urandom_range(0, 242));
        w[8*j +: 8] = b;
      end
      send_word(w, $urandom_range(0, NB - 1));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rdy_mode = 0;
    check("rand_err", 32'(err_o), 32'(model_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
